exe_alu_stage: RTL and testbench

- Execute stage of the ARM pipeline. Directly consumes val2 from the second-operand generator and val1 from the ID/EXE path.
- Computes the ALU result and holds the NZCV status register.
- Registers the result plus memory/write-back controls into the EXE/MEM boundary with one-cycle latency.
- Supports pipeline stall and flush.

---
 rtl/exe_alu_stage.sv | 135 +++++++++++++
 tb/tb_exe_alu_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_alu_stage.sv
// ARM execute stage: ALU, NZCV status register and EXE/MEM pipeline register with stall/flush.
// Optional EXE_BRANCH_ADDR_EN adds a registered branch target (pc + sext(imm24) << 2).
module exe_alu_stage #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned REG_ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  in_valid,
   input  logic [3:0]            exe_cmd,
   input  logic                  s_bit,
   input  logic [WIDTH-1:0]      val1,
   input  logic [WIDTH-1:0]      val2,
   input  logic [WIDTH-1:0]      val_rm,
   input  logic                  mem_r_en,
   input  logic                  mem_w_en,
   input  logic                  wb_en,
   input  logic [REG_ADDR_W-1:0] dest,
`ifdef EXE_BRANCH_ADDR_EN
   input  logic [WIDTH-1:0]      pc,
   input  logic [23:0]           imm24,
   output logic [WIDTH-1:0]      branch_addr,
`endif
   output logic                  out_valid,
   output logic [WIDTH-1:0]      alu_result,
   output logic [WIDTH-1:0]      st_val,
   output logic                  out_mem_r_en,
   output logic                  out_mem_w_en,
   output logic                  out_wb_en,
   output logic [REG_ADDR_W-1:0] out_dest,
   output logic [3:0]            status
);

   localparam logic [3:0] CmdMov = 4'b0001;
   localparam logic [3:0] CmdMvn = 4'b1001;
   localparam logic [3:0] CmdAdd = 4'b0010;
   localparam logic [3:0] CmdAdc = 4'b0011;
   localparam logic [3:0] CmdSub = 4'b0100;
   localparam logic [3:0] CmdSbc = 4'b0101;
   localparam logic [3:0] CmdAnd = 4'b0110;
   localparam logic [3:0] CmdOrr = 4'b0111;
   localparam logic [3:0] CmdEor = 4'b1000;

   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH:0]   sum;
   logic             cin;
   logic             arith;
   logic             legal;
   logic             flag_c;
   logic             flag_v;
   logic [3:0]       new_status;

   always_comb begin
      result = '0;
      op_b   = val2;
      cin    = 1'b0;
      arith  = 1'b0;
      legal  = 1'b1;
      // Subtraction is val1 + ~val2 + cin so the carry-out is ARM's NOT-borrow directly.
      unique case (exe_cmd)
         CmdAdd: begin arith = 1'b1; end
         CmdAdc: begin arith = 1'b1; cin = status[1]; end
         CmdSub: begin arith = 1'b1; op_b = ~val2; cin = 1'b1; end
         CmdSbc: begin arith = 1'b1; op_b = ~val2; cin = status[1]; end
         default: ;
      endcase
      sum = {1'b0, val1} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
      unique case (exe_cmd)
         CmdMov: result = val2;
         CmdMvn: result = ~val2;
         CmdAdd, CmdAdc, CmdSub, CmdSbc: result = sum[WIDTH-1:0];
         CmdAnd: result = val1 & val2;
         CmdOrr: result = val1 | val2;
         CmdEor: result = val1 ^ val2;
         default: begin result = '0; legal = 1'b0; end
      endcase
   end

   always_comb begin
      flag_c = status[1];
      flag_v = status[0];
      if (arith) begin
         flag_c = sum[WIDTH];
         flag_v = (val1[WIDTH-1] == op_b[WIDTH-1]) && (result[WIDTH-1] != val1[WIDTH-1]);
      end
      new_status = {result[WIDTH-1], (result == '0), flag_c, flag_v};
   end

`ifdef EXE_BRANCH_ADDR_EN
   logic [WIDTH-1:0] branch_next;
   assign branch_next = pc + {{(WIDTH-26){imm24[23]}}, imm24, 2'b00};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         branch_addr <= '0;
      end else if (!flush && !stall) begin
         branch_addr <= branch_next;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid    <= 1'b0;
         alu_result   <= '0;
         st_val       <= '0;
         out_mem_r_en <= 1'b0;
         out_mem_w_en <= 1'b0;
         out_wb_en    <= 1'b0;
         out_dest     <= '0;
         status       <= '0;
      end else if (flush) begin
         // Data outputs hold; only the bubble's enables are cleared.
         out_valid    <= 1'b0;
         out_mem_r_en <= 1'b0;
         out_mem_w_en <= 1'b0;
         out_wb_en    <= 1'b0;
      end else if (!stall) begin
         out_valid    <= in_valid;
         alu_result   <= result;
         st_val       <= val_rm;
         out_mem_r_en <= in_valid & mem_r_en;
         out_mem_w_en <= in_valid & mem_w_en;
         out_wb_en    <= in_valid & wb_en;
         out_dest     <= dest;
         if (in_valid && s_bit && legal) begin
            status <= new_status;
         end
      end
   end

endmodule

// File: tb/tb_exe_alu_stage.sv
// Directed self-checking bench for exe_alu_stage (covers EXE_BRANCH_ADDR_EN when defined).
module tb_exe_alu_stage;

   logic        clk = 1'b0;
   logic        rst, stall, flush, in_valid, s_bit;
   logic [3:0]  exe_cmd;
   logic [31:0] val1, val2, val_rm;
   logic        mem_r_en, mem_w_en, wb_en;
   logic [3:0]  dest;
   logic        out_valid, out_mem_r_en, out_mem_w_en, out_wb_en;
   logic [31:0] alu_result, st_val;
   logic [3:0]  out_dest, status;
`ifdef EXE_BRANCH_ADDR_EN
   logic [31:0] pc, branch_addr;
   logic [23:0] imm24;
`endif

   int checks = 0;
   int errors = 0;

   exe_alu_stage #(.WIDTH(32), .REG_ADDR_W(4)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
      .exe_cmd(exe_cmd), .s_bit(s_bit), .val1(val1), .val2(val2), .val_rm(val_rm),
      .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en), .dest(dest),
`ifdef EXE_BRANCH_ADDR_EN
      .pc(pc), .imm24(imm24), .branch_addr(branch_addr),
`endif
      .out_valid(out_valid), .alu_result(alu_result), .st_val(st_val),
      .out_mem_r_en(out_mem_r_en), .out_mem_w_en(out_mem_w_en), .out_wb_en(out_wb_en),
      .out_dest(out_dest), .status(status)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [3:0] cmd, input logic s, input logic [31:0] a,
                         input logic [31:0] b);
      in_valid = 1'b1;
      exe_cmd  = cmd;
      s_bit    = s;
      val1     = a;
      val2     = b;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      checks++;
      if ({out_valid, out_wb_en, out_mem_r_en, out_mem_w_en} !== 4'b0 || alu_result !== 32'h0 ||
          st_val !== 32'h0 || out_dest !== 4'h0 || status !== 4'h0) begin
         errors++;
         $display("FAIL reset_initial: valid=%b result=%h status=%b, required all zero",
                  out_valid, alu_result, status);
      end
      rst = 1'b0;
   endtask

   task automatic test_add_flags();
      set_op(4'b0010, 1'b1, 32'hFFFF_FFFF, 32'h1);
      wb_en = 1'b1;
      dest  = 4'd7;
      step();
      checks++;
      if (alu_result !== 32'h0 || status !== 4'b0110) begin
         errors++;
         $display("FAIL add_flags: result=%h status=%b, required 0 / 0110", alu_result, status);
      end
      checks++;
      if (out_valid !== 1'b1 || out_wb_en !== 1'b1 || out_dest !== 4'd7) begin
         errors++;
         $display("FAIL add_ctrl: valid=%b wb=%b dest=%0d, required 1/1/7",
                  out_valid, out_wb_en, out_dest);
      end
   endtask

   task automatic test_sub_adc_sbc();
      set_op(4'b0100, 1'b1, 32'h8000_0000, 32'h1);
      step();
      checks++;
      if (alu_result !== 32'h7FFF_FFFF || status !== 4'b0011) begin
         errors++;
         $display("FAIL sub_overflow: result=%h status=%b, required 7fffffff / 0011",
                  alu_result, status);
      end
      // ADC consumes C=1 from the SUB just captured.
      set_op(4'b0011, 1'b1, 32'd5, 32'd3);
      step();
      checks++;
      if (alu_result !== 32'd9 || status !== 4'b0000) begin
         errors++;
         $display("FAIL adc_carry: result=%h status=%b, required 9 / 0000", alu_result, status);
      end
      // SBC with C=0: 10 - 3 - 1 = 6, no borrow -> C=1.
      set_op(4'b0101, 1'b1, 32'd10, 32'd3);
      step();
      checks++;
      if (alu_result !== 32'd6 || status !== 4'b0010) begin
         errors++;
         $display("FAIL sbc_borrow: result=%h status=%b, required 6 / 0010", alu_result, status);
      end
   endtask

   task automatic test_stall_flush();
      set_op(4'b0010, 1'b1, 32'hFFFF_FFFF, 32'h1);
      wb_en = 1'b1;
      step();
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         set_op(4'b0001, 1'b1, 32'h0, 32'h1234 + i);
         step();
         checks++;
         if (alu_result !== 32'h0 || status !== 4'b0110 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold%0d: result=%h status=%b valid=%b, required 0/0110/1",
                     i, alu_result, status, out_valid);
         end
      end
      flush = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b0 || out_wb_en !== 1'b0 || status !== 4'b0110) begin
         errors++;
         $display("FAIL flush_over_stall: valid=%b wb=%b status=%b, required 0/0/0110",
                  out_valid, out_wb_en, status);
      end
      stall = 1'b0;
      flush = 1'b0;
      set_op(4'b0001, 1'b1, 32'h0, 32'h1234);
      step();
      checks++;
      if (alu_result !== 32'h1234 || status !== 4'b0010 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL resume_mov: result=%h status=%b valid=%b, required 1234/0010/1",
                  alu_result, status, out_valid);
      end
   endtask

   task automatic test_logic_flags();
      set_op(4'b0100, 1'b1, 32'h8000_0000, 32'h1);
      step();
      set_op(4'b1000, 1'b1, 32'hF0F0, 32'hF0F0);
      step();
      checks++;
      if (alu_result !== 32'h0 || status !== 4'b0111) begin
         errors++;
         $display("FAIL eor_keeps_cv: result=%h status=%b, required 0 / 0111", alu_result, status);
      end
      set_op(4'b0001, 1'b0, 32'h0, 32'h8000_0000);
      step();
      checks++;
      if (alu_result !== 32'h8000_0000 || status !== 4'b0111) begin
         errors++;
         $display("FAIL mov_no_s: result=%h status=%b, required 80000000 / 0111",
                  alu_result, status);
      end
      set_op(4'b1111, 1'b1, 32'h5, 32'h6);
      step();
      checks++;
      if (alu_result !== 32'h0 || status !== 4'b0111) begin
         errors++;
         $display("FAIL illegal_cmd: result=%h status=%b, required 0 / 0111", alu_result, status);
      end
      set_op(4'b1001, 1'b1, 32'h0, 32'h0);
      step();
      checks++;
      if (alu_result !== 32'hFFFF_FFFF || status !== 4'b1011) begin
         errors++;
         $display("FAIL mvn_flags: result=%h status=%b, required ffffffff / 1011",
                  alu_result, status);
      end
   endtask

   task automatic test_invalid_and_store();
      set_op(4'b0010, 1'b1, 32'h1, 32'h1);
      in_valid = 1'b0;
      wb_en    = 1'b1;
      mem_r_en = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b0 || out_wb_en !== 1'b0 || out_mem_r_en !== 1'b0 ||
          status !== 4'b1011) begin
         errors++;
         $display("FAIL invalid_gate: valid=%b wb=%b mr=%b status=%b, required 0/0/0/1011",
                  out_valid, out_wb_en, out_mem_r_en, status);
      end
      set_op(4'b0010, 1'b0, 32'h1000, 32'h24);
      wb_en    = 1'b0;
      mem_r_en = 1'b0;
      mem_w_en = 1'b1;
      val_rm   = 32'hDEAD_BEEF;
      dest     = 4'd3;
      step();
      checks++;
      if (alu_result !== 32'h1024 || st_val !== 32'hDEAD_BEEF || out_mem_w_en !== 1'b1 ||
          out_wb_en !== 1'b0 || out_dest !== 4'd3) begin
         errors++;
         $display("FAIL store: addr=%h data=%h mw=%b wb=%b dest=%0d, required 1024/deadbeef/1/0/3",
                  alu_result, st_val, out_mem_w_en, out_wb_en, out_dest);
      end
      mem_w_en = 1'b0;
   endtask

`ifdef EXE_BRANCH_ADDR_EN
   task automatic test_branch();
      set_op(4'b0001, 1'b0, 32'h0, 32'h0);
      pc    = 32'h100;
      imm24 = 24'hFFFFFE;
      step();
      checks++;
      if (branch_addr !== 32'hF8) begin
         errors++;
         $display("FAIL branch_addr: got %h, required 000000f8", branch_addr);
      end
   endtask
`endif

   task automatic test_reset_mid();
      set_op(4'b1001, 1'b1, 32'h0, 32'h0);
      wb_en = 1'b1;
      step();
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({out_valid, out_wb_en, out_mem_r_en, out_mem_w_en} !== 4'b0 || alu_result !== 32'h0 ||
          st_val !== 32'h0 || out_dest !== 4'h0 || status !== 4'h0) begin
         errors++;
         $display("FAIL reset_async: valid=%b result=%h status=%b, required all zero",
                  out_valid, alu_result, status);
      end
      step();
      rst = 1'b0;
      set_op(4'b0001, 1'b0, 32'h0, 32'h77);
      step();
      checks++;
      if (alu_result !== 32'h77 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_capture: result=%h valid=%b, required 77/1",
                  alu_result, out_valid);
      end
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; s_bit = 1'b0;
      exe_cmd = 4'h0; val1 = '0; val2 = '0; val_rm = '0;
      mem_r_en = 1'b0; mem_w_en = 1'b0; wb_en = 1'b0; dest = '0;
`ifdef EXE_BRANCH_ADDR_EN
      pc = '0; imm24 = '0;
`endif
      test_reset();
      test_add_flags();
      test_sub_adc_sbc();
      test_stall_flush();
      test_logic_flags();
      test_invalid_and_store();
`ifdef EXE_BRANCH_ADDR_EN
      test_branch();
`endif
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
